tlm_hdl2hvl_mfifo: RTL and testbench

TLM_HDL2HVL_MFIFO -- requirements
Module: tlm_hdl2hvl_mfifo

---
 rtl/tlm_hdl2hvl_pkg.sv | 15 +
 rtl/tlm_fifo_chan.sv | 65 ++++++
 rtl/tlm_hdl2hvl_mfifo.sv | 107 ++++++++++
 tb/tb_tlm_hdl2hvl_mfifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tlm_hdl2hvl_pkg.sv
// Shared types and helpers for the HDL-to-HVL multi-channel FIFO.
package tlm_hdl2hvl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } get_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tlm_fifo_chan.sv
// One channel: circular word store with pointers, occupancy count and
// backpressure or discard-on-full behaviour.
module tlm_fifo_chan
  import tlm_hdl2hvl_pkg::*;
#(
  parameter int unsigned Twidth        = 32,
  parameter int unsigned Tdepth        = 4,
  parameter bit          Tdrop_on_full = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [Twidth-1:0] wdata_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic [Twidth-1:0] head_o
);

  localparam int unsigned AW = clog2_min1(Tdepth);

  logic [Twidth-1:0] mem_q [Tdepth];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              full, wr_en, rd_en;

  assign full       = (cnt_q == (AW+1)'(Tdepth));
  assign empty_o    = (cnt_q == '0);
  assign ready_o    = Tdrop_on_full ? 1'b1 : !full;
  assign overflow_o = ovf_q;
  assign head_o     = mem_q[rptr_q];
  assign wr_en      = push_i && !full;
  assign rd_en      = pop_i && !empty_o;

  // Pointers wrap naturally because Tdepth is a power of two.
  always_comb begin
    wptr_d = wptr_q + AW'(wr_en);
    rptr_d = rptr_q + AW'(rd_en);
    cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    ovf_d  = ovf_q | (Tdrop_on_full && push_i && full);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Data store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tlm_hdl2hvl_mfifo.sv
// Multi-channel HDL-to-HVL FIFO: per-channel writers, one blocking get port
// that pops a word from a selected channel.
module tlm_hdl2hvl_mfifo
  import tlm_hdl2hvl_pkg::*;
#(
  parameter int unsigned Twidth        = 32,
  parameter int unsigned Tdepth        = 4,
  parameter int unsigned Tchannels     = 2,
  parameter int unsigned Tdrop_on_full = 0,
  parameter int unsigned CW            = clog2_min1(Tchannels)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [Tchannels-1:0]        valid,
  output logic [Tchannels-1:0]        ready,
  input  logic [Tchannels*Twidth-1:0] dat_i,
  input  logic                        get_req,
  input  logic [CW-1:0]               get_chan,
  output logic                        get_busy,
  output logic                        get_ack,
  output logic [Twidth-1:0]           get_dat,
  output logic [Tchannels-1:0]        empty,
  output logic [Tchannels-1:0]        overflow
);

  localparam int unsigned NSLOT = 1 << CW;

  get_state_e        state_q, state_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [Twidth-1:0] dat_q, dat_d;
  logic              pop_en;
  logic [Twidth-1:0] head_w [NSLOT];
  logic [NSLOT-1:0]  slot_empty;
  logic [NSLOT-1:0]  slot_ok;

  // Unused index slots read as empty and out of range.
  for (genvar c = 0; c < NSLOT; c++) begin : g_chan
    if (c < Tchannels) begin : g_real
      tlm_fifo_chan #(
        .Twidth       (Twidth),
        .Tdepth       (Tdepth),
        .Tdrop_on_full(Tdrop_on_full != 0)
      ) u_chan (
        .clock     (clock),
        .reset     (reset),
        .push_i    (valid[c]),
        .wdata_i   (dat_i[c*Twidth +: Twidth]),
        .pop_i     (pop_en && (chan_q == CW'(c))),
        .ready_o   (ready[c]),
        .empty_o   (slot_empty[c]),
        .overflow_o(overflow[c]),
        .head_o    (head_w[c])
      );
      assign slot_ok[c] = 1'b1;
    end else begin : g_pad
      assign head_w[c]     = '0;
      assign slot_empty[c] = 1'b1;
      assign slot_ok[c]    = 1'b0;
    end
  end

  assign empty    = slot_empty[Tchannels-1:0];
  assign get_busy = (state_q != IDLE);
  assign get_ack  = (state_q == ACK);
  assign get_dat  = dat_q;

  // Get FSM: latch channel, block until data, pop and present for one cycle.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    dat_d   = dat_q;
    pop_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (get_req) begin
          chan_d  = get_chan;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!slot_ok[chan_q]) begin
          dat_d   = '0;
          state_d = ACK;
        end else if (!slot_empty[chan_q]) begin
          pop_en  = 1'b1;
          dat_d   = head_w[chan_q];
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      chan_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dat_q   <= dat_d;
    end
  end

endmodule

// File: tb/tb_tlm_hdl2hvl_mfifo.sv
// Scoreboard bench: a backpressure instance (2 channels) and a discard-on-full
// instance (3 channels, so an out-of-range channel index exists).
module tb_tlm_hdl2hvl_mfifo;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Instance 0: Tchannels=2, backpressure
  logic [1:0]  valid0 = '0, ready0, empty0, ovf0;
  logic [63:0] dat0 = '0;
  logic        gr0 = 1'b0, gc0 = 1'b0, busy0, ack0;
  logic [31:0] gdat0;

  // Instance 1: Tchannels=3, discard on full
  logic [2:0]  valid1 = '0, ready1, empty1, ovf1;
  logic [95:0] dat1 = '0;
  logic        gr1 = 1'b0, busy1, ack1;
  logic [1:0]  gc1 = '0;
  logic [31:0] gdat1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  tlm_hdl2hvl_mfifo #(.Twidth(32), .Tdepth(4), .Tchannels(2), .Tdrop_on_full(0)) dut0 (
    .clock(clock), .reset(reset), .valid(valid0), .ready(ready0), .dat_i(dat0),
    .get_req(gr0), .get_chan(gc0), .get_busy(busy0), .get_ack(ack0),
    .get_dat(gdat0), .empty(empty0), .overflow(ovf0));

  tlm_hdl2hvl_mfifo #(.Twidth(32), .Tdepth(4), .Tchannels(3), .Tdrop_on_full(1)) dut1 (
    .clock(clock), .reset(reset), .valid(valid1), .ready(ready1), .dat_i(dat1),
    .get_req(gr1), .get_chan(gc1), .get_busy(busy1), .get_ack(ack1),
    .get_dat(gdat1), .empty(empty1), .overflow(ovf1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every ack pops the scoreboard and compares the word
  always @(negedge clock) begin
    if (ack0) begin
      if (q0.size() == 0) chk("dut0_unexpected_ack", 64'(gdat0), 64'hDEAD);
      else begin
        automatic logic [31:0] e = q0.pop_front();
        chk("dut0_get_dat", 64'(gdat0), 64'(e));
      end
    end
  end

  always @(negedge clock) begin
    if (ack1) begin
      if (q1.size() == 0) chk("dut1_unexpected_ack", 64'(gdat1), 64'hDEAD);
      else begin
        automatic logic [31:0] e = q1.pop_front();
        chk("dut1_get_dat", 64'(gdat1), 64'(e));
      end
    end
  end

  // Issue a get from a negedge where data is already present
  task automatic get0(input logic ch, input logic [31:0] exp);
    q0.push_back(exp);
    gr0 = 1'b1; gc0 = ch;
    @(negedge clock); gr0 = 1'b0;
    chk("get0_wait", {ack0, busy0}, 2'b01);
    @(negedge clock);
    chk("get0_ack", {ack0, busy0}, 2'b11);
    @(negedge clock);
    chk("get0_idle", {ack0, busy0}, 2'b00);
  endtask

  task automatic get1(input logic [1:0] ch, input logic [31:0] exp);
    q1.push_back(exp);
    gr1 = 1'b1; gc1 = ch;
    @(negedge clock); gr1 = 1'b0;
    chk("get1_wait", {ack1, busy1}, 2'b01);
    @(negedge clock);
    chk("get1_ack", {ack1, busy1}, 2'b11);
    @(negedge clock);
    chk("get1_idle", {ack1, busy1}, 2'b00);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_empty0", empty0, 2'b11);
    chk("rst_ready0", ready0, 2'b11);
    chk("rst_ovf0", ovf0, 2'b00);
    chk("rst_get0", {ack0, busy0}, 2'b00);
    chk("rst_gdat0", gdat0, 32'h0);
    chk("rst_empty1", empty1, 3'b111);
    chk("rst_ready1", ready1, 3'b111);
    @(negedge clock);

    // Fill channel 0 straight out of reset; data increments every cycle
    reset = 1'b0; valid0 = 2'b01; dat0[31:0] = 32'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      chk($sformatf("fill_ready_%0d", k), ready0[0], (k < 4) ? 1'b1 : 1'b0);
      if (k == 1) chk("fill_empty", empty0, 2'b10);
      dat0[31:0] = 32'(k + 1);
    end
    valid0 = 2'b00;
    for (int i = 1; i <= 4; i++) get0(1'b0, 32'(i));
    chk("drain_empty", empty0, 2'b11);

    // Blocking get on empty channel 1, request held high while busy
    gr0 = 1'b1; gc0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("block_busy", {ack0, busy0}, 2'b01);
    end
    gr0 = 1'b0;
    q0.push_back(32'hA5);
    valid0 = 2'b10; dat0[63:32] = 32'hA5;
    @(negedge clock); valid0 = 2'b00;
    chk("block_after_write", {ack0, busy0}, 2'b01);
    @(negedge clock);
    chk("block_ack", {ack0, busy0}, 2'b11);
    @(negedge clock);
    chk("block_idle", {ack0, busy0}, 2'b00);

    // Interleaved channels
    for (int i = 0; i < 3; i++) begin
      valid0 = 2'b11; dat0 = {32'(32'h200 + i), 32'(32'h100 + i)};
      @(negedge clock);
    end
    valid0 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      get0(1'b0, 32'(32'h100 + i));
      get0(1'b1, 32'(32'h200 + i));
    end
    chk("inter_empty", empty0, 2'b11);

    // Full channel: pop concurrent with an offered write
    valid0 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      dat0[31:0] = 32'(32'h300 + i);
      @(negedge clock);
    end
    chk("full_ready", ready0[0], 1'b0);
    dat0[31:0] = 32'h3FF;
    q0.push_back(32'h300);
    gr0 = 1'b1; gc0 = 1'b0;
    @(negedge clock); gr0 = 1'b0;
    chk("full_wait", {ack0, busy0}, 2'b01);
    chk("full_still", ready0[0], 1'b0);
    @(negedge clock); valid0 = 2'b00;
    chk("full_ack", {ack0, busy0}, 2'b11);
    chk("full_count3", ready0[0], 1'b1);
    @(negedge clock);
    for (int i = 1; i < 4; i++) get0(1'b0, 32'(32'h300 + i));
    chk("full_drained", empty0, 2'b11);

    // Discard-on-full instance
    valid1 = 3'b001;
    for (int i = 0; i < 6; i++) begin
      dat1[31:0] = 32'(10 + i);
      @(negedge clock);
      chk("drop_ready", ready1, 3'b111);
    end
    valid1 = 3'b000;
    chk("drop_ovf", ovf1, 3'b001);
    for (int i = 0; i < 4; i++) get1(2'd0, 32'(10 + i));
    chk("drop_empty", empty1, 3'b111);
    get1(2'd3, 32'h0);
    chk("drop_ovf_sticky", ovf1, 3'b001);
    chk("oor_empty", empty1, 3'b111);

    // Reset during a pending get
    valid0 = 2'b01; dat0[31:0] = 32'h55;
    @(negedge clock); valid0 = 2'b00;
    gr0 = 1'b1; gc0 = 1'b1;
    @(negedge clock); gr0 = 1'b0;
    chk("pend_busy", {ack0, busy0}, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_get0", {ack0, busy0}, 2'b00);
    chk("mid_rst_empty0", empty0, 2'b11);
    chk("mid_rst_ready0", ready0, 2'b11);
    chk("mid_rst_gdat0", gdat0, 32'h0);
    chk("mid_rst_ovf1", ovf1, 3'b000);
    chk("mid_rst_gdat1", gdat1, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("in_rst_ack", {ack0, busy0}, 2'b00);
    end
    reset = 1'b0; valid0 = 2'b10; dat0[63:32] = 32'h77;
    @(negedge clock); valid0 = 2'b00;
    chk("post_rst_busy", busy0, 1'b0);
    chk("post_rst_write", empty0, 2'b01);
    get0(1'b1, 32'h77);

    @(negedge clock);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
